// File: rtl/ex_operand_stage_pkg.sv
// ============================================================================
// ex_operand_stage_pkg : shared ALU control codes, operand source selects and
//                        the control half of the ID/EX stage register.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_operand_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd9;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'd10;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src1;
        logic                  alu_src2;
        logic                  reg_write;
    } ex_ctrl_t;

    // Bubble: not valid, no writeback, rd=x0, ALU idles on ADD.
    function automatic ex_ctrl_t ctrl_bubble();
        ex_ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
// ============================================================================
// fwd_mux : RAW-hazard forward select for one source register; MEM beats WB,
//           x0 never forwarded. WB path present only with EX_FWD_WB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]       i_reg_data,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]       i_mem_result,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]       i_wb_result,
    output logic [XLEN-1:0]       o_data
);

    logic w_addr_nz;
    logic w_mem_hit;

    assign w_addr_nz = |i_addr;
    assign w_mem_hit = i_mem_reg_write && (i_mem_rd_addr == i_addr) && w_addr_nz;

`ifdef EX_FWD_WB_EN
    logic w_wb_hit;
    assign w_wb_hit = i_wb_reg_write && (i_wb_rd_addr == i_addr) && w_addr_nz;

    always_comb begin
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
        end
    end
`else
    // WB tuple stays on the port list but has no effect in this build.
    logic w_unused_wb;
    assign w_unused_wb = ^{i_wb_reg_write, i_wb_rd_addr, i_wb_result};

    always_comb begin
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// ex_operand_stage : ID/EX stage register with MEM/WB operand forwarding and
//                    ALU operand selection. Optional macro: EX_FWD_WB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  IdValid,
    input  logic [XLEN-1:0]       IdPC,
    input  logic [XLEN-1:0]       IdRs1Data,
    input  logic [XLEN-1:0]       IdRs2Data,
    input  logic [XLEN-1:0]       IdImm,
    input  logic [REG_ADDR_W-1:0] IdRs1Addr,
    input  logic [REG_ADDR_W-1:0] IdRs2Addr,
    input  logic [REG_ADDR_W-1:0] IdRdAddr,
    input  logic [ALU_CTRL_W-1:0] IdAluContrl,
    input  logic                  IdAluSrc1,
    input  logic                  IdAluSrc2,
    input  logic                  IdRegWrite,
    input  logic                  MemRegWrite,
    input  logic [REG_ADDR_W-1:0] MemRdAddr,
    input  logic [XLEN-1:0]       MemResult,
    input  logic                  WbRegWrite,
    input  logic [REG_ADDR_W-1:0] WbRdAddr,
    input  logic [XLEN-1:0]       WbResult,
    output logic [XLEN-1:0]       Operand1,
    output logic [XLEN-1:0]       Operand2,
    output logic [ALU_CTRL_W-1:0] AluContrl,
    output logic                  ExValid,
    output logic                  ExRegWrite,
    output logic [REG_ADDR_W-1:0] ExRdAddr,
    output logic [XLEN-1:0]       ExStoreData,
    output logic [XLEN-1:0]       ExPC
);

    ex_ctrl_t        r_ctrl;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;

    ex_ctrl_t        w_id_ctrl;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign w_id_ctrl = '{
        valid:     IdValid,
        rs1_addr:  IdRs1Addr,
        rs2_addr:  IdRs2Addr,
        rd_addr:   IdRdAddr,
        alu_ctrl:  IdAluContrl,
        alu_src1:  IdAluSrc1,
        alu_src2:  IdAluSrc2,
        reg_write: IdRegWrite
    };

    // During a stall the data fields re-capture their forwarded value so a
    // result retiring from MEM/WB mid-stall is not lost once it leaves the pipe.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_ctrl     <= ctrl_bubble();
            r_pc       <= RESET_PC;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else if (FlushE) begin
            r_ctrl     <= ctrl_bubble();
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else if (StallE) begin
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end else begin
            r_ctrl     <= w_id_ctrl;
            r_pc       <= IdPC;
            r_rs1_data <= IdRs1Data;
            r_rs2_data <= IdRs2Data;
            r_imm      <= IdImm;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_addr          (r_ctrl.rs1_addr),
        .i_reg_data      (r_rs1_data),
        .i_mem_reg_write (MemRegWrite),
        .i_mem_rd_addr   (MemRdAddr),
        .i_mem_result    (MemResult),
        .i_wb_reg_write  (WbRegWrite),
        .i_wb_rd_addr    (WbRdAddr),
        .i_wb_result     (WbResult),
        .o_data          (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_addr          (r_ctrl.rs2_addr),
        .i_reg_data      (r_rs2_data),
        .i_mem_reg_write (MemRegWrite),
        .i_mem_rd_addr   (MemRdAddr),
        .i_mem_result    (MemResult),
        .i_wb_reg_write  (WbRegWrite),
        .i_wb_rd_addr    (WbRdAddr),
        .i_wb_result     (WbResult),
        .o_data          (w_fwd_rs2)
    );

    assign Operand1    = (r_ctrl.alu_src1 == SRC1_PC)  ? r_pc  : w_fwd_rs1;
    assign Operand2    = (r_ctrl.alu_src2 == SRC2_IMM) ? r_imm : w_fwd_rs2;
    assign ExStoreData = w_fwd_rs2;
    assign AluContrl   = r_ctrl.alu_ctrl;
    assign ExValid     = r_ctrl.valid;
    assign ExRegWrite  = r_ctrl.reg_write & r_ctrl.valid;
    assign ExRdAddr    = r_ctrl.rd_addr;
    assign ExPC        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// ============================================================================
// tb_ex_operand_stage : directed self-checking bench for ex_operand_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_operand_stage;

    logic        CLK;
    logic        RST_n;
    logic        StallE, FlushE;
    logic        IdValid;
    logic [31:0] IdPC, IdRs1Data, IdRs2Data, IdImm;
    logic [4:0]  IdRs1Addr, IdRs2Addr, IdRdAddr;
    logic [3:0]  IdAluContrl;
    logic        IdAluSrc1, IdAluSrc2, IdRegWrite;
    logic        MemRegWrite, WbRegWrite;
    logic [4:0]  MemRdAddr, WbRdAddr;
    logic [31:0] MemResult, WbResult;
    logic [31:0] Operand1, Operand2, ExStoreData, ExPC;
    logic [3:0]  AluContrl;
    logic        ExValid, ExRegWrite;
    logic [4:0]  ExRdAddr;

    int checks   = 0;
    int failures = 0;

    // Hand-coded ALU codes: ADD=3, SUB=4.
    localparam logic [3:0] C_ADD = 4'd3;
    localparam logic [3:0] C_SUB = 4'd4;

`ifdef EX_FWD_WB_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    ex_operand_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST_n(RST_n), .StallE(StallE), .FlushE(FlushE),
        .IdValid(IdValid), .IdPC(IdPC), .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data),
        .IdImm(IdImm), .IdRs1Addr(IdRs1Addr), .IdRs2Addr(IdRs2Addr), .IdRdAddr(IdRdAddr),
        .IdAluContrl(IdAluContrl), .IdAluSrc1(IdAluSrc1), .IdAluSrc2(IdAluSrc2),
        .IdRegWrite(IdRegWrite), .MemRegWrite(MemRegWrite), .MemRdAddr(MemRdAddr),
        .MemResult(MemResult), .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr),
        .WbResult(WbResult), .Operand1(Operand1), .Operand2(Operand2),
        .AluContrl(AluContrl), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
        .ExRdAddr(ExRdAddr), .ExStoreData(ExStoreData), .ExPC(ExPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic v, input logic [31:0] pc,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] alu, input logic s1, input logic s2,
                        input logic rw);
        IdValid = v; IdPC = pc; IdRs1Addr = a1; IdRs1Data = d1;
        IdRs2Addr = a2; IdRs2Data = d2; IdImm = imm; IdRdAddr = rd;
        IdAluContrl = alu; IdAluSrc1 = s1; IdAluSrc2 = s2; IdRegWrite = rw;
    endtask

    task automatic fwd_clear();
        MemRegWrite = 1'b0; MemRdAddr = 5'd0; MemResult = 32'h0;
        WbRegWrite  = 1'b0; WbRdAddr  = 5'd0; WbResult  = 32'h0;
    endtask

    initial begin
        RST_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        fwd_clear();
        // Reset with busy ID inputs: nothing may leak through.
        load(1'b1, 32'h0000_0444, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222,
             32'h3333_3333, 5'd9, C_SUB, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rst_valid",    {31'b0, ExValid},    32'd0);
        chk("rst_regwrite", {31'b0, ExRegWrite}, 32'd0);
        chk("rst_aluctrl",  {28'b0, AluContrl},  32'd3);
        chk("rst_op1",      Operand1,            32'h0);
        chk("rst_op2",      Operand2,            32'h0);
        chk("rst_store",    ExStoreData,         32'h0);
        chk("rst_rd",       {27'b0, ExRdAddr},   32'd0);
        chk("rst_pc",       ExPC,                32'h0);

        // addi x6, x5, 3 with x5 = 7
        @(negedge CLK);
        RST_n = 1'b1;
        load(1'b1, 32'h0000_0040, 5'd5, 32'd7, 5'd0, 32'd0,
             32'd3, 5'd6, C_ADD, 1'b0, 1'b1, 1'b1);
        tick();
        chk("addi_op1",   Operand1,            32'd7);
        chk("addi_op2",   Operand2,            32'd3);
        chk("addi_valid", {31'b0, ExValid},    32'd1);
        chk("addi_rw",    {31'b0, ExRegWrite}, 32'd1);
        chk("addi_rd",    {27'b0, ExRdAddr},   32'd6);
        chk("addi_pc",    ExPC,                32'h40);

        // Forward priority on rs1 = x3; rs2 = x4 unaffected
        load(1'b1, 32'h0000_0044, 5'd3, 32'h0000_1111, 5'd4, 32'h0000_2222,
             32'h0, 5'd7, C_SUB, 1'b0, 1'b0, 1'b1);
        tick();
        chk("sub_alu", {28'b0, AluContrl}, 32'd4);
        chk("nofwd_op1", Operand1, 32'h0000_1111);
        MemRegWrite = 1'b1; MemRdAddr = 5'd3; MemResult = 32'hAAAA_0000;
        WbRegWrite  = 1'b1; WbRdAddr  = 5'd3; WbResult  = 32'h0000_5555;
        #1;
        chk("fwd_mem_prio", Operand1, 32'hAAAA_0000);
        chk("fwd_rs2_nohit", Operand2, 32'h0000_2222);
        MemResult = 32'hAAAA_0001;
        #1;
        chk("fwd_zero_cycle", Operand1, 32'hAAAA_0001);
        MemRegWrite = 1'b0;
        #1;
        chk("fwd_wb", Operand1, WB_ON ? 32'h0000_5555 : 32'h0000_1111);
        fwd_clear();

        // x0 guard on rs2
        load(1'b1, 32'h0000_0048, 5'd1, 32'h0, 5'd0, 32'h0,
             32'h0000_0010, 5'd8, C_ADD, 1'b0, 1'b1, 1'b1);
        tick();
        MemRegWrite = 1'b1; MemRdAddr = 5'd0; MemResult = 32'hDEAD_BEEF;
        WbRegWrite  = 1'b1; WbRdAddr  = 5'd0; WbResult  = 32'h0000_CAFE;
        #1;
        chk("x0_store", ExStoreData, 32'h0);
        chk("x0_op2",   Operand2,    32'h0000_0010);
        fwd_clear();

        // Stall reload via WB: x7 retires in first stall cycle only
        load(1'b1, 32'h0000_004C, 5'd0, 32'h0, 5'd7, 32'h0000_0BAD,
             32'h0, 5'd8, C_ADD, 1'b0, 1'b0, 1'b1);
        tick();
        StallE = 1'b1;
        WbRegWrite = 1'b1; WbRdAddr = 5'd7; WbResult = 32'h0000_1234;
        load(1'b1, 32'h0000_0050, 5'd2, 32'h0, 5'd2, 32'h0000_9999,
             32'h0, 5'd15, C_SUB, 1'b0, 1'b0, 1'b1);
        #1;
        chk("stall_wb_live", ExStoreData, WB_ON ? 32'h0000_1234 : 32'h0000_0BAD);
        tick();
        fwd_clear();
        #1;
        chk("stall_wb_held1", ExStoreData, WB_ON ? 32'h0000_1234 : 32'h0000_0BAD);
        chk("stall_rd_hold",  {27'b0, ExRdAddr}, 32'd8);
        tick();
        StallE = 1'b0;
        #1;
        chk("stall_wb_release", ExStoreData, WB_ON ? 32'h0000_1234 : 32'h0000_0BAD);
        chk("stall_alu_hold",   {28'b0, AluContrl}, 32'd3);
        tick();
        chk("post_stall_rd", {27'b0, ExRdAddr}, 32'd15);

        // Stall reload via MEM on rs1 = x9
        load(1'b1, 32'h0000_0054, 5'd9, 32'h0000_0001, 5'd0, 32'h0,
             32'h0, 5'd10, C_ADD, 1'b0, 1'b1, 1'b1);
        tick();
        StallE = 1'b1;
        MemRegWrite = 1'b1; MemRdAddr = 5'd9; MemResult = 32'h0000_0077;
        tick();
        fwd_clear();
        #1;
        chk("stall_mem_reload", Operand1, 32'h0000_0077);
        StallE = 1'b0;

        // Invalid instruction suppresses ExRegWrite
        load(1'b0, 32'h0000_0058, 5'd0, 32'h0, 5'd0, 32'h0,
             32'h0, 5'd11, C_ADD, 1'b0, 1'b0, 1'b1);
        tick();
        chk("inv_rw", {31'b0, ExRegWrite}, 32'd0);

        // Flush beats stall
        load(1'b1, 32'h0000_005C, 5'd1, 32'h0000_00AA, 5'd0, 32'h0,
             32'h0, 5'd12, C_SUB, 1'b0, 1'b0, 1'b1);
        tick();
        chk("pre_flush_valid", {31'b0, ExValid}, 32'd1);
        FlushE = 1'b1; StallE = 1'b1;
        tick();
        FlushE = 1'b0; StallE = 1'b0;
        chk("flush_valid", {31'b0, ExValid},    32'd0);
        chk("flush_rw",    {31'b0, ExRegWrite}, 32'd0);
        chk("flush_rd",    {27'b0, ExRdAddr},   32'd0);
        chk("flush_alu",   {28'b0, AluContrl},  32'd3);
        chk("flush_op1",   Operand1,            32'h0);

        // AUIPC
        load(1'b1, 32'h0000_0100, 5'd0, 32'h0, 5'd0, 32'h0,
             32'h0000_2000, 5'd10, C_ADD, 1'b1, 1'b1, 1'b1);
        tick();
        chk("auipc_op1", Operand1, 32'h0000_0100);
        chk("auipc_op2", Operand2, 32'h0000_2000);

        // Asynchronous reset between edges
        #1;
        RST_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, ExValid}, 32'd0);
        chk("arst_op1",   Operand1,         32'h0);
        chk("arst_op2",   Operand2,         32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        tick();
        chk("arst_recapture", Operand1, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX boundary register and operand-forwarding front end of the execute stage. Captures decoded fields from ID each cycle and resolves RAW hazards by forwarding MEM and WB results. Selects register, PC or immediate sources and presents `Operand1`, `Operand2` and `AluContrl` directly to the ALU. Also supplies the forwarded rs2 store data and the destination tag to EX/MEM.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value held in the register after reset.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST_n` in 1: reset, asynchronous, active-low.
- `StallE` in 1: hold the stage contents.
- `FlushE` in 1: load a bubble.
- `IdValid` in 1: ID holds a real instruction.
- `IdPC` in XLEN: instruction PC.
- `IdRs1Data`, `IdRs2Data` in XLEN: register-file read data.
- `IdImm` in XLEN: sign-extended immediate.
- `IdRs1Addr`, `IdRs2Addr`, `IdRdAddr` in 5: register indices.
- `IdAluContrl` in 4: ALU op, encoded with the shared ALU control codes.
- `IdAluSrc1` in 1: operand 1 source; 0 = rs1, 1 = PC.
- `IdAluSrc2` in 1: operand 2 source; 0 = rs2, 1 = immediate.
- `IdRegWrite` in 1: instruction writes rd.
- `MemRegWrite` in 1, `MemRdAddr` in 5, `MemResult` in XLEN: forward source from EX/MEM.
- `WbRegWrite` in 1, `WbRdAddr` in 5, `WbResult` in XLEN: forward source from MEM/WB.
- `Operand1`, `Operand2` out XLEN: ALU operands.
- `AluContrl` out 4: registered ALU op.
- `ExValid` out 1: EX holds a real instruction.
- `ExRegWrite` out 1: equals registered RegWrite AND ExValid.
- `ExRdAddr` out 5: registered rd.
- `ExStoreData` out XLEN: forwarded rs2 value, independent of AluSrc2.
- `ExPC` out XLEN: registered PC.

## Operation
- Stage register fields: Valid, PC, Rs1Data, Rs2Data, Imm, Rs1Addr, Rs2Addr, RdAddr, AluContrl, AluSrc1, AluSrc2, RegWrite.
- Forwarding for each of rs1 and rs2, combinational, from the registered address and data:
  - If `MemRegWrite` and `MemRdAddr` equals the address and the address is nonzero, use `MemResult`.
  - Otherwise, if `WbRegWrite` and `WbRdAddr` equals the address and the address is nonzero, use `WbResult`.
  - Otherwise use the registered data.
  - MEM takes priority over WB; x0 is never forwarded.
- Operand selection:
  - `Operand1` = AluSrc1 ? PC : fwd rs1.
  - `Operand2` = AluSrc2 ? Imm : fwd rs2.
  - `ExStoreData` = fwd rs2.
- Register update priority at each clock edge:
  - `FlushE` (highest): Valid=0, RegWrite=0, RdAddr=0, AluContrl=`ADD`; other fields are don't-care but are loaded as 0.
  - `StallE`: all fields hold, except Rs1Data and Rs2Data, which reload with their forwarded values. This keeps a result that retires from WB during a stall.
  - Otherwise: load all fields from the `Id*` inputs; Valid = `IdValid`.
- `FlushE` and `StallE` asserted together: flush wins.
- Load-use hazards are not detected here; the hazard unit drives `StallE`/`FlushE`.
- All outputs are pure functions of registered state plus the current forward inputs. There is no arithmetic beyond the XLEN-wide muxes.

## Timing
- Latency: `Id*` sampled at edge N appear on the outputs after edge N.
- Forward path is zero-cycle: a change on `MemResult`/`WbResult` propagates to `Operand1`/`Operand2` in the same cycle.
- Reset values: Valid=0, RegWrite=0, RdAddr=0, AluContrl=`ADD`, PC=`RESET_PC`, data/imm/addr fields=0. Consequently `Operand1`=`Operand2`=0, `ExStoreData`=0, `ExValid`=0, `ExRegWrite`=0.
- Reset asserted mid-operation clears all fields immediately, without waiting for `CLK`. The first capture is at the first rising edge after deassertion.
- Stall for K cycles: outputs stay stable except through forwarding. The instruction issues once, when the stall releases.

## Configuration
- `EX_FWD_WB_EN` defined: WB forwarding path present as described.
- Undefined: only the MEM forward path is present. `WbRegWrite`, `WbRdAddr` and `WbResult` remain ports but are ignored. The register file must write-first, and the hazard unit covers the distance-2 dependency. The stall-time reload uses the MEM path only.

## Structure
- Shared package: the ALU control codes (already in `Parameters.v`), plus new constants `SRC1_RS1`, `SRC1_PC`, `SRC2_RS2` and `SRC2_IMM`.
- One sub-module, `fwd_mux`: inputs are address, register data and the two forward tuples; output is the selected data. It is instantiated twice (rs1, rs2).

## Test plan
- Reset: hold `RST_n`=0 with arbitrary `Id*` -> `ExValid`=0, `ExRegWrite`=0, `AluContrl`=`ADD`, `Operand1`=`Operand2`=0; release, then load `addi` rs1=x5 (data 7), imm=3 -> next cycle `Operand1`=7, `Operand2`=3.
- Forward priority: EX rs1=x3; MEM rd=x3 result 0xAAAA_0000; WB rd=x3 result 0x5555 -> `Operand1`=0xAAAA_0000. Drop `MemRegWrite` -> `Operand1`=0x5555.
- x0 guard: rs2=x0 with `MemRdAddr`=0, `MemRegWrite`=1, `MemResult`=0xDEAD_BEEF -> `ExStoreData`=0.
- Stall reload: stall 2 cycles; WB writes x7=0x1234 in the first stall cycle only; EX rs2=x7 -> after release, `ExStoreData`=0x1234.
- Flush vs stall: assert `FlushE` and `StallE` together -> next cycle `ExValid`=0, `ExRegWrite`=0, `ExRdAddr`=0.
- AUIPC: `IdAluSrc1`=1, PC=0x100, imm=0x2000 -> `Operand1`=0x100, `Operand2`=0x2000.
